// File: rtl/reg_rmw_seq.sv
// rtl/reg_rmw_seq.sv - read-modify-write sequencer for an external register file
// Define REG_RMW_SEQ_FWD_EN to forward the last written value to a same-address follow-up request.
module reg_rmw_seq #(
    parameter int D_WIDTH = 16,
    parameter int REG_NO  = 16,
    parameter int A_WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [1:0]         req_op,
    input  logic [A_WIDTH-1:0] req_addr,
    input  logic [D_WIDTH-1:0] req_operand,
    output logic               rsp_valid,
    output logic [D_WIDTH-1:0] rsp_data,
    output logic               rsp_zr,
    output logic               rsp_ng,
    output logic               rf_cs,
    output logic               rf_we,
    output logic [A_WIDTH-1:0] rf_addr,
    output logic [D_WIDTH-1:0] rf_din,
    input  logic [D_WIDTH-1:0] rf_dout
);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RSP} state_t;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_AND  = 2'b10;
    localparam logic [1:0] OP_SWAP = 2'b11;

    if (REG_NO < 1 || REG_NO > (1 << A_WIDTH)) begin : g_cfg_check
        $error("reg_rmw_seq: REG_NO must lie in 1 .. 2**A_WIDTH");
    end

    state_t               state_q, state_d;
    logic [1:0]           op_q, op_d;
    logic [A_WIDTH-1:0]   addr_q, addr_d;
    logic [D_WIDTH-1:0]   opnd_q, opnd_d;
    logic [D_WIDTH-1:0]   new_q, new_d;
    logic [D_WIDTH-1:0]   old_q, old_d;
    logic [A_WIDTH-1:0]   last_addr_q, last_addr_d;
    logic [D_WIDTH-1:0]   last_din_q, last_din_d;
    logic [D_WIDTH-1:0]   rsp_q, rsp_d;
    logic                 zr_q, zr_d;
    logic                 ng_q, ng_d;
    logic                 fwd_hit;
    logic [D_WIDTH-1:0]   old_val;
    logic [D_WIDTH-1:0]   new_val;

`ifdef REG_RMW_SEQ_FWD_EN
    logic                 tag_vld_q;
    logic                 fwd_q;
    logic [A_WIDTH-1:0]   tag_addr_q;
    logic [D_WIDTH-1:0]   tag_val_q;

    // The tag mirrors the register file exactly because this block is its only writer.
    assign fwd_hit = tag_vld_q && (req_addr == tag_addr_q);
    assign old_val = fwd_q ? tag_val_q : rf_dout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_vld_q  <= 1'b0;
            fwd_q      <= 1'b0;
            tag_addr_q <= '0;
            tag_val_q  <= '0;
        end else begin
            if (state_q == S_IDLE && req_valid) begin
                fwd_q <= fwd_hit;
            end
            if (state_q == S_WR) begin
                tag_vld_q  <= 1'b1;
                tag_addr_q <= addr_q;
                tag_val_q  <= new_val;
            end
        end
    end
`else
    assign fwd_hit = 1'b0;
    assign old_val = rf_dout;
`endif

    always_comb begin
        case (op_q)
            OP_ADD:  new_val = old_val + opnd_q;
            OP_SUB:  new_val = old_val - opnd_q;
            OP_AND:  new_val = old_val & opnd_q;
            default: new_val = opnd_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            addr_q      <= '0;
            opnd_q      <= '0;
            new_q       <= '0;
            old_q       <= '0;
            last_addr_q <= '0;
            last_din_q  <= '0;
            rsp_q       <= '0;
            zr_q        <= 1'b0;
            ng_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            opnd_q      <= opnd_d;
            new_q       <= new_d;
            old_q       <= old_d;
            last_addr_q <= last_addr_d;
            last_din_q  <= last_din_d;
            rsp_q       <= rsp_d;
            zr_q        <= zr_d;
            ng_q        <= ng_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        opnd_d      = opnd_q;
        new_d       = new_q;
        old_d       = old_q;
        last_addr_d = last_addr_q;
        last_din_d  = last_din_q;
        rsp_d       = rsp_q;
        zr_d        = zr_q;
        ng_d        = ng_q;
        req_ready   = (state_q == S_IDLE) & ~rst;
        rsp_valid   = 1'b0;
        rf_cs       = 1'b0;
        rf_we       = 1'b0;
        rf_addr     = last_addr_q;
        rf_din      = last_din_q;
        rsp_data    = rsp_q;
        rsp_zr      = zr_q;
        rsp_ng      = ng_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    op_d    = req_op;
                    addr_d  = req_addr;
                    opnd_d  = req_operand;
                    state_d = fwd_hit ? S_WR : S_RD;
                end
            end
            S_RD: begin
                rf_cs   = 1'b1;
                rf_addr = addr_q;
                state_d = S_WR;
            end
            S_WR: begin
                rf_cs       = 1'b1;
                rf_we       = 1'b1;
                rf_addr     = addr_q;
                rf_din      = new_val;
                new_d       = new_val;
                old_d       = old_val;
                last_addr_d = addr_q;
                last_din_d  = new_val;
                state_d     = S_RSP;
            end
            S_RSP: begin
                rsp_valid = 1'b1;
                rsp_data  = (op_q == OP_SWAP) ? old_q : new_q;
                rsp_zr    = (rsp_data == '0);
                rsp_ng    = rsp_data[D_WIDTH-1];
                rsp_d     = rsp_data;
                zr_d      = rsp_zr;
                ng_d      = rsp_ng;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_reg_rmw_seq.sv
// tb/tb_reg_rmw_seq.sv - self-checking bench for reg_rmw_seq with a behavioural register file
module tb_reg_rmw_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [3:0]  req_addr = 4'h0;
    logic [15:0] req_operand = 16'h0;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_zr;
    logic        rsp_ng;
    logic        rf_cs;
    logic        rf_we;
    logic [3:0]  rf_addr;
    logic [15:0] rf_din;
    logic [15:0] rf_dout;

    always #5 clk = ~clk;

    reg_rmw_seq #(.D_WIDTH(16), .REG_NO(16), .A_WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_operand(req_operand),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_zr(rsp_zr), .rsp_ng(rsp_ng),
        .rf_cs(rf_cs), .rf_we(rf_we), .rf_addr(rf_addr), .rf_din(rf_din), .rf_dout(rf_dout)
    );

`ifdef REG_RMW_SEQ_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic [15:0] mem [16];
    logic        mem_init = 1'b1;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) mem[i] <= (i == 7) ? 16'h00AA : 16'h0000;
            rf_dout <= 16'h0000;
        end else if (rf_cs) begin
            if (rf_we) begin
                mem[rf_addr] <= rf_din;
                rf_dout      <= rf_din;
            end else begin
                rf_dout <= mem[rf_addr];
            end
        end
    end

    int          total = 0;
    int          bad = 0;
    logic [15:0] ref_mem [16];
    bit          tag_ok;
    logic [3:0]  tag_addr;

    typedef struct {
        logic [1:0]  op;
        logic [3:0]  addr;
        logic [15:0] x;
        logic [15:0] exp_d;
        logic        exp_zr;
        logic        exp_ng;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] new_of(input logic [1:0] op, input logic [15:0] old, input logic [15:0] x);
        case (op)
            2'd0:    return old + x;
            2'd1:    return old - x;
            2'd2:    return old & x;
            default: return x;
        endcase
    endfunction

    // Issues one request and checks timing, strobe width, hold and the register file write.
    task automatic run_req(input string name, input logic [1:0] op, input logic [3:0] addr,
                           input logic [15:0] x, output logic [15:0] got, output logic gzr, output logic gng);
        logic [15:0] nv, expv;
        bit          hit, rd;
        int          guard, k_we, k_rsp;
        nv   = new_of(op, ref_mem[addr], x);
        expv = (op == 2'd3) ? ref_mem[addr] : nv;
        hit  = FWD && tag_ok && (tag_addr == addr);
        got = 16'h0; gzr = 1'b0; gng = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_operand = x;
        guard = 0;
        while (!req_ready && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        chk({name, " accept"}, guard < 10, 1);
        k_we = -1; k_rsp = -1; rd = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = 1'b0;
            if (rf_cs && !rf_we) rd = 1'b1;
            if (rf_we && k_we < 0) k_we = k;
            if (rsp_valid) begin
                k_rsp = k; got = rsp_data; gzr = rsp_zr; gng = rsp_ng;
                break;
            end
        end
        chk({name, " write cycle"}, k_we, hit ? 1 : 2);
        chk({name, " rsp cycle"}, k_rsp, hit ? 2 : 3);
        chk({name, " read taken"}, rd, !hit);
        @(negedge clk);
        chk({name, " strobe width"}, rsp_valid, 0);
        chk({name, " rsp hold"}, rsp_data, expv);
        ref_mem[addr] = nv;
        tag_ok = 1'b1;
        tag_addr = addr;
        chk({name, " rf contents"}, mem[addr], nv);
    endtask

    initial begin
        logic [15:0] got, expv;
        logic        gzr, gng;
        int          acc [$];
        int          exp_acc [$];
        int          pos, evts;
        bit          t_ok;
        logic [1:0]  rop;
        logic [3:0]  raddr;
        logic [15:0] rx;

        vecs[0] = '{2'd0, 4'd3,  16'h0005, 16'h0005, 1'b0, 1'b0};
        vecs[1] = '{2'd1, 4'd3,  16'h0006, 16'hFFFF, 1'b0, 1'b1};
        vecs[2] = '{2'd2, 4'd3,  16'h0000, 16'h0000, 1'b1, 1'b0};
        vecs[3] = '{2'd3, 4'd7,  16'h1234, 16'h00AA, 1'b0, 1'b0};
        vecs[4] = '{2'd0, 4'd3,  16'hFFFF, 16'hFFFF, 1'b0, 1'b1};
        vecs[5] = '{2'd0, 4'd3,  16'h0001, 16'h0000, 1'b1, 1'b0};
        vecs[6] = '{2'd3, 4'd15, 16'h8000, 16'h0000, 1'b1, 1'b0};
        vecs[7] = '{2'd2, 4'd15, 16'hF0F0, 16'h8000, 1'b0, 1'b1};
        vecs[8] = '{2'd3, 4'd7,  16'h0000, 16'h1234, 1'b0, 1'b0};

        for (int i = 0; i < 16; i++) ref_mem[i] = (i == 7) ? 16'h00AA : 16'h0000;
        tag_ok = 1'b0;
        tag_addr = 4'h0;

        repeat (3) @(negedge clk);
        chk("reset ready", req_ready, 0);
        chk("reset outputs", {rsp_valid, rf_cs, rf_we, rsp_zr, rsp_ng}, 0);
        chk("reset addr/din/data", {rf_addr, rf_din, rsp_data}, 0);
        rst = 1'b0;
        mem_init = 1'b0;
        #1;
        chk("ready after reset", req_ready, 1);

        for (int i = 0; i < 9; i++) begin
            run_req($sformatf("vec%0d", i), vecs[i].op, vecs[i].addr, vecs[i].x, got, gzr, gng);
            chk($sformatf("vec%0d data", i), got, vecs[i].exp_d);
            chk($sformatf("vec%0d zr", i), gzr, vecs[i].exp_zr);
            chk($sformatf("vec%0d ng", i), gng, vecs[i].exp_ng);
        end
        chk("swap target", mem[7], 16'h0000);

        // Continuous request: acceptance spacing comes from the per-request hit rule.
        pos = 0;
        t_ok = tag_ok && (tag_addr == 4'd5);
        while (pos < 24) begin
            exp_acc.push_back(pos);
            pos += (FWD && t_ok) ? 3 : 4;
            t_ok = 1'b1;
        end
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'd0; req_addr = 4'd5; req_operand = 16'h0001;
        for (int c = 0; c < 24; c++) begin
            if (req_ready) begin
                acc.push_back(c);
                chk("ready only in idle", {rf_cs, rsp_valid}, 0);
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("accept count", acc.size(), exp_acc.size());
        for (int i = 0; i < acc.size() && i < exp_acc.size(); i++)
            chk($sformatf("accept cycle %0d", i), acc[i], exp_acc[i]);
        ref_mem[5] = ref_mem[5] + 16'(acc.size());
        tag_ok = 1'b1;
        tag_addr = 4'd5;
        chk("continuous rf", mem[5], ref_mem[5]);

        // Abort during the read phase.
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'd0; req_addr = 4'd2; req_operand = 16'h0009;
        @(negedge clk);
        req_valid = 1'b0;
        chk("abort in read", {rf_cs, rf_we}, 2'b10);
        rst = 1'b1;
        #1;
        chk("abort ready", req_ready, 0);
        chk("abort outputs", {rsp_valid, rf_cs, rf_we, rsp_zr, rsp_ng}, 0);
        chk("abort addr/din/data", {rf_addr, rf_din, rsp_data}, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ready after abort", req_ready, 1);
        evts = 0;
        for (int c = 0; c < 6; c++) begin
            if (rf_we || rsp_valid) evts++;
            @(negedge clk);
        end
        chk("abort no write/rsp", evts, 0);
        chk("abort reg2", mem[2], ref_mem[2]);
        tag_ok = 1'b0;
        expv = ref_mem[2] + 16'h0009;
        run_req("post abort", 2'd0, 4'd2, 16'h0009, got, gzr, gng);
        chk("post abort data", got, expv);

        for (int n = 0; n < 40; n++) begin
            rop   = 2'($urandom_range(0, 3));
            raddr = 4'($urandom_range(0, 3));
            rx    = ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom);
            expv  = (rop == 2'd3) ? ref_mem[raddr] : new_of(rop, ref_mem[raddr], rx);
            run_req($sformatf("rnd%0d", n), rop, raddr, rx, got, gzr, gng);
            chk($sformatf("rnd%0d data", n), got, expv);
            chk($sformatf("rnd%0d zr", n), gzr, expv == 16'h0000);
            chk($sformatf("rnd%0d ng", n), gng, expv[15]);
        end

        for (int i = 0; i < 16; i++) chk($sformatf("final reg%0d", i), mem[i], ref_mem[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_rmw_seq.md
REG_RMW_SEQ -- requirements
Module: reg_rmw_seq

Interface
REQ-001 SHALL have parameter D_WIDTH, default 16, data width of register file words.
REQ-002 SHALL have parameter REG_NO, default 16, number of registers addressed.
REQ-003 SHALL have parameter A_WIDTH, default 4, register address width.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port req_valid  input  1  request present.
REQ-007 SHALL have port req_ready  output  1  request accepted when high with req_valid.
REQ-008 SHALL have port req_op  input  2  00 ADD, 01 SUB, 10 AND, 11 SWAP.
REQ-009 SHALL have port req_addr  input  A_WIDTH  target register.
REQ-010 SHALL have port req_operand  input  D_WIDTH  operand.
REQ-011 SHALL have port rsp_valid  output  1  single-cycle result strobe, no backpressure.
REQ-012 SHALL have port rsp_data  output  D_WIDTH  result (see REQ-020).
REQ-013 SHALL have port rsp_zr / rsp_ng  output  1 each  rsp_data==0 / rsp_data MSB.
REQ-014 SHALL have port rf_cs, rf_we  output  1 each; rf_addr  output  A_WIDTH; rf_din  output  D_WIDTH; rf_dout  input  D_WIDTH: downstream register file, one-cycle registered read, write-through dout.

Function
REQ-015 SHALL implement FSM IDLE -> RD -> WR -> RSP -> IDLE; block is sole master of the register file.
REQ-016 SHALL drive req_ready = (state==IDLE) & ~rst; on req_valid&req_ready latch op/addr/operand, go RD.
REQ-017 RD: rf_cs=1, rf_we=0, rf_addr=latched addr; next state WR.
REQ-018 WR: rf_dout holds old value; rf_cs=1, rf_we=1, rf_addr=latched addr, rf_din=new value computed combinationally; latch new and old values; next state RSP.
REQ-019 New value: ADD old+operand, SUB old-operand, AND old&operand, SWAP operand; arithmetic modulo 2^D_WIDTH, carry/borrow discarded.
REQ-020 RSP: rsp_valid=1 for exactly one cycle; rsp_data = new value for ADD/SUB/AND, old value for SWAP; flags derived from rsp_data; next state IDLE.
REQ-021 Latency: request accepted at cycle T -> RD at T+1, write at T+2, rsp_valid at T+3; throughput one request per 4 cycles.
REQ-022 rf_cs=0, rf_we=0 in IDLE and RSP; rf_addr/rf_din hold last values outside RD/WR.
REQ-023 rsp_data/flags SHALL hold last response between strobes.
REQ-024 req_addr >= REG_NO SHALL be passed through unchanged; no range check.

Reset
REQ-025 rst asserted SHALL immediately force state IDLE, req_ready=0, rsp_valid=0, rf_cs=0, rf_we=0, rf_addr=0, rf_din=0, rsp_data=0, rsp_zr=0, rsp_ng=0.
REQ-026 Reset mid-operation SHALL abort without write or response; req_ready=1 in the first cycle after deassertion.

Configuration
REQ-027 Macro REG_RMW_SEQ_FWD_EN SHALL enable same-address forwarding: a tag (addr, new value, valid) is set at WR and cleared by reset.
REQ-028 With REG_RMW_SEQ_FWD_EN, accepted request whose addr equals valid tag SHALL skip RD, go IDLE -> WR using tagged value as old value; latency T+1 write, T+2 rsp_valid.
REQ-029 Without REG_RMW_SEQ_FWD_EN, every request SHALL take RD; no tag logic present.

Verification
REQ-030 Reset, then ADD addr 3 operand 5 with reg3=0 -> rf write 5 at T+2, rsp_valid T+3, rsp_data=5, zr=0, ng=0.
REQ-031 SUB addr 3 operand 6 with reg3=5 -> write 0xFFFF, rsp_data=0xFFFF, ng=1; AND operand 0 -> rsp_data=0, zr=1.
REQ-032 SWAP addr 7 operand 0x1234 with reg7=0x00AA -> reg7=0x1234, rsp_data=0x00AA.
REQ-033 req_valid held high continuously -> req_ready high only in IDLE, exactly one acceptance per 4 cycles (3 with FWD_EN on repeated address).
REQ-034 rst asserted during RD of ADD addr 2 -> no rf_we pulse, no rsp_valid, reg2 unchanged, next request accepted normally.
REQ-035 With REG_RMW_SEQ_FWD_EN: ADD addr 1 operand 1 twice back-to-back from 0 -> second skips RD (no read cs), rsp_data=2; different address -> RD taken.
